sa_input_skewer: RTL and testbench
==================================

// Module: sa_input_skewer
// PURPOSE
//   Upstream feeder for a row of PE_units in the reconfigurable systolic array.
//   Accepts one NUM_LANES-wide operand vector per beat and emits it diagonally skewed.
//   Lane i is delayed by i+1 advance cycles, so operands meet their partners in-array
//   in WS/IS/OS modes. After a burst ends (in_last), it injects zero bubbles to flush the skew.
// PARAMETERS
//   DATA_WIDTH  16  width of one operand lane (matches PE input_0/input_2)
//   NUM_LANES   4   number of lanes = PE rows fed; >= 1
// PORTS
//   clk         in   1                      rising-edge clock
//   rst_n       in   1                      asynchronous active-low reset
//   in_valid    in   1                      upstream vector valid
//   in_ready    out  1                      skewer accepts vector this cycle
//   in_data     in   NUM_LANES*DATA_WIDTH   lane i = bits [i*DW +: DW]
//   in_last     in   1                      qualifies final vector of a burst
//   out_ready   in   1                      array advance enable (0 = stall)
//   out_data    out  NUM_LANES*DATA_WIDTH   skewed operands, lane i to PE row i
//   out_valid   out  NUM_LANES              per-lane valid of out_data
//   busy        out  1                      burst in flight or data in skew lines
//   drain_done  out  1                      1-cycle pulse when flush completes
// BEHAVIOUR
//   - Reset, async, any state: all skew registers, out_data, out_valid, drain_done = 0.
//     FSM goes to IDLE and the drain counter is cleared.
//   - adv = out_ready. Nothing changes on a cycle where adv=0.
//     All outputs hold and in_ready=0.
//   - accept = in_valid & in_ready. Data transfers only on accept.
//   - in_ready = out_ready & (state != DRAIN).
//   - Lane i holds a chain of i+1 registers, each with data and valid bits.
//     On adv, the chain shifts one stage toward the output.
//     Stage 0 loads in_data lane i with valid=1 on accept; otherwise it loads 0 with valid=0.
//   - out_data[i] and out_valid[i] come from the last stage of lane i (registered output).
//     Latency: vector accepted at edge k appears on lane i after edge k+i, given no stalls.
//   - Bubbles carry data 0, so PE MACs accumulate nothing from them.
//   - FSM states:
//       IDLE   -> STREAM on accept with in_last=0.
//       IDLE   -> DRAIN on accept with in_last=1, when NUM_LANES>1.
//       STREAM -> DRAIN on accept with in_last=1.
//       STREAM holds while in_valid is low; bubbles enter.
//       DRAIN: counter loads NUM_LANES-1 on entry and decrements on each adv.
//              When it is 1 and adv occurs, go to IDLE and pulse drain_done.
//       With NUM_LANES=1, in_last returns directly to IDLE and drain_done pulses on the accept edge.
//   - busy = (state != IDLE) | (|valid bits in any chain stage).
//   - Stall in DRAIN freezes the counter. A stall never drops or duplicates data.
//   - in_last without in_valid is ignored. in_data is don't-care when not accepted.
//   - No wrap-around. The counter is $clog2(NUM_LANES)+1 bits and never underflows.
// TESTING
//   1 Reset: drive rst_n=0 mid-burst with 3 lanes holding valid data.
//     -> out_valid=0, out_data=0, busy=0, in_ready=0 while in reset.
//     -> in_ready=1 on the first cycle after release with out_ready=1.
//   2 Skew: NUM_LANES=4, one vector {4,3,2,1} (lane0=1) with in_last=1, out_ready=1.
//     -> lane0=1 after edge+0, lane1=2 after +1, lane2=3 after +2, lane3=4 after +3.
//     -> drain_done pulses with lane3 valid.
//   3 Back-to-back: 3 vectors 0x0010,0x0020,0x0030 (all lanes same value), last on the third.
//     -> each lane shows 3 consecutive valid beats, offset by the lane index.
//     -> in_ready=0 for exactly 3 cycles after the last accept.
//   4 Stall: deassert out_ready for 2 cycles mid-DRAIN.
//     -> out_data and out_valid are frozen and in_ready=0.
//     -> flush resumes and drain_done arrives 2 cycles later than in the no-stall case.
//   5 Gap: in_valid low for 1 cycle between two vectors.
//     -> each lane shows a valid=0, data=0 bubble between the beats.
//     -> state stays STREAM and busy=1.
//   6 Integration: lane0 of a 1-lane skewer feeds a PE_unit input_2 in WS mode, preload=10.
//     Send vector 5 with input_1=100. -> PE output_1=150 one cycle after out_valid[0].

Source files
------------

// File: rtl/sa_input_skewer_if.sv
// Handshake/data bundle for sa_input_skewer: upstream vector port, skewed array port, status.
// master = the side feeding vectors and consuming skewed lanes; slave = the skewer itself.
interface sa_input_skewer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_LANES  = 4
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
  logic                            in_last;
  logic                            out_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0] out_data;
  logic [NUM_LANES-1:0]            out_valid;
  logic                            busy;
  logic                            drain_done;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_data, out_valid, busy, drain_done
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_data, out_valid, busy, drain_done
  );
endinterface

// File: rtl/sa_input_skewer.sv
// Diagonal input skewer for a systolic PE row: lane i is delayed by i+1 advance cycles,
// and after the last vector of a burst zero bubbles are shifted in until the skew is flushed.
module sa_input_skewer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_LANES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sa_input_skewer_if.slave   sif
);

  localparam int unsigned CntW = $clog2(NUM_LANES) + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_d;
  logic                r_drain_done;
  logic                w_drain_done_d;
  logic                w_adv;
  logic                w_accept;
  logic [NUM_LANES-1:0] w_lane_busy;

  assign w_adv          = sif.out_ready;
  assign sif.in_ready   = sif.out_ready & (r_state != StDrain);
  assign w_accept       = sif.in_valid & sif.in_ready;
  assign sif.busy       = (r_state != StIdle) | (|w_lane_busy);
  assign sif.drain_done = r_drain_done;

  // Lane i owns i+1 stages; stage 0 takes the new operand or a zero bubble.
  for (genvar gl = 0; gl < NUM_LANES; gl++) begin : g_lane
    localparam int unsigned Depth = gl + 1;

    logic [DATA_WIDTH-1:0] r_dat [Depth];
    logic [Depth-1:0]      r_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < Depth; s++) begin
          r_dat[s] <= '0;
        end
        r_vld <= '0;
      end else if (w_adv) begin
        r_dat[0] <= w_accept ? sif.in_data[gl*DATA_WIDTH +: DATA_WIDTH] : '0;
        r_vld[0] <= w_accept;
        for (int s = 1; s < Depth; s++) begin
          r_dat[s] <= r_dat[s-1];
          r_vld[s] <= r_vld[s-1];
        end
      end
    end

    assign sif.out_data[gl*DATA_WIDTH +: DATA_WIDTH] = r_dat[Depth-1];
    assign sif.out_valid[gl]                         = r_vld[Depth-1];
    assign w_lane_busy[gl]                           = |r_vld;
  end

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_drain_done_d = 1'b0;
    unique case (r_state)
      StIdle, StStream: begin
        if (w_accept && sif.in_last) begin
          if (NUM_LANES > 1) begin
            w_state_d = StDrain;
            w_cnt_d   = CntW'(NUM_LANES - 1);
          end else begin
            // A single lane has no skew to flush.
            w_state_d      = StIdle;
            w_drain_done_d = 1'b1;
          end
        end else if (w_accept) begin
          w_state_d = StStream;
        end
      end
      StDrain: begin
        if (r_cnt <= CntW'(1)) begin
          w_state_d      = StIdle;
          w_cnt_d        = '0;
          w_drain_done_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Everything, including the done pulse, freezes while the array is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_drain_done <= 1'b0;
    end else if (w_adv) begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_drain_done <= w_drain_done_d;
    end
  end

endmodule

// File: tb/tb_sa_input_skewer.sv
// Directed bench for sa_input_skewer: reset, skew, back-to-back, stall, gap,
// and a 1-lane instance feeding a simple weight-stationary PE model.
module tb_sa_input_skewer;
  localparam int unsigned DW = 16;
  localparam int unsigned NL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_input_skewer_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();
  sa_input_skewer_if #(.DATA_WIDTH(DW), .NUM_LANES(1))  bus1 ();

  sa_input_skewer #(.DATA_WIDTH(DW), .NUM_LANES(NL)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus.slave)
  );

  sa_input_skewer #(.DATA_WIDTH(DW), .NUM_LANES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus1.slave)
  );

  // Weight-stationary PE: preload weight 10, partial sum in 100.
  logic [DW-1:0] pe_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe_out <= '0;
    else if (bus1.out_valid[0]) pe_out <= DW'(100 + 10 * bus1.out_data);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NL-1:0]      ev;
  logic [NL*DW-1:0]   ed;
  int                 k;

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_last   = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset mid-burst with three lanes holding data
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = {4{16'h1111}};
    tick();
    bus.in_data = {4{16'h2222}};
    tick();
    bus.in_data = {4{16'h3333}};
    tick();
    check("rst_pre_valid", 64'(bus.out_valid), 64'(4'b0111));
    #2;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_done", 64'(bus.drain_done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("rst_release_ready", 64'(bus.in_ready), 64'd1);

    // 2: single vector, lane i appears i cycles after the accept edge
    bus.in_valid = 1'b1;
    bus.in_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("skew_v0", 64'(bus.out_valid), 64'(4'b0001));
    check("skew_d0", 64'(bus.out_data), 64'h0000_0000_0000_0001);
    check("skew_ready0", 64'(bus.in_ready), 64'd0);
    check("skew_busy0", 64'(bus.busy), 64'd1);
    check("skew_done0", 64'(bus.drain_done), 64'd0);
    tick();
    check("skew_v1", 64'(bus.out_valid), 64'(4'b0010));
    check("skew_d1", 64'(bus.out_data), 64'h0000_0000_0002_0000);
    tick();
    check("skew_v2", 64'(bus.out_valid), 64'(4'b0100));
    check("skew_d2", 64'(bus.out_data), 64'h0000_0003_0000_0000);
    check("skew_done2", 64'(bus.drain_done), 64'd0);
    tick();
    check("skew_v3", 64'(bus.out_valid), 64'(4'b1000));
    check("skew_d3", 64'(bus.out_data), 64'h0004_0000_0000_0000);
    check("skew_done3", 64'(bus.drain_done), 64'd1);
    check("skew_ready3", 64'(bus.in_ready), 64'd1);
    tick();
    check("skew_v4", 64'(bus.out_valid), 64'd0);
    check("skew_done4", 64'(bus.drain_done), 64'd0);
    check("skew_busy4", 64'(bus.busy), 64'd0);

    // 3: back-to-back burst of three vectors
    bus.in_valid = 1'b1;
    bus.in_data  = {4{16'h0010}};
    for (int t = 0; t < 7; t++) begin
      tick();
      ev = '0;
      ed = '0;
      for (int i = 0; i < NL; i++) begin
        k = t - i;
        if (k >= 0 && k <= 2) begin
          ev[i]           = 1'b1;
          ed[i*DW +: DW]  = DW'(16 * (k + 1));
        end
      end
      check($sformatf("b2b_v%0d", t), 64'(bus.out_valid), 64'(ev));
      check($sformatf("b2b_d%0d", t), 64'(bus.out_data), 64'(ed));
      check($sformatf("b2b_ready%0d", t), 64'(bus.in_ready), (t >= 2 && t <= 4) ? 64'd0 : 64'd1);
      check($sformatf("b2b_done%0d", t), 64'(bus.drain_done), (t == 5) ? 64'd1 : 64'd0);
      if (t == 0) begin
        bus.in_data = {4{16'h0020}};
      end else if (t == 1) begin
        bus.in_data = {4{16'h0030}};
        bus.in_last = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
    end
    check("b2b_busy_end", 64'(bus.busy), 64'd0);

    // 4: two-cycle stall in the middle of the drain
    bus.in_valid = 1'b1;
    bus.in_data  = {16'd8, 16'd7, 16'd6, 16'd5};
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    check("stall_pre_v", 64'(bus.out_valid), 64'(4'b0010));
    bus.out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      check($sformatf("stall_v%0d", s), 64'(bus.out_valid), 64'(4'b0010));
      check($sformatf("stall_d%0d", s), 64'(bus.out_data), 64'h0000_0000_0006_0000);
      check($sformatf("stall_ready%0d", s), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall_done%0d", s), 64'(bus.drain_done), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("stall_res_v2", 64'(bus.out_valid), 64'(4'b0100));
    check("stall_res_d2", 64'(bus.out_data), 64'h0000_0007_0000_0000);
    check("stall_res_done2", 64'(bus.drain_done), 64'd0);
    tick();
    check("stall_res_v3", 64'(bus.out_valid), 64'(4'b1000));
    check("stall_res_d3", 64'(bus.out_data), 64'h0008_0000_0000_0000);
    check("stall_res_done3", 64'(bus.drain_done), 64'd1);
    tick();

    // 5: one-cycle gap between two vectors of a burst
    bus.in_valid = 1'b1;
    bus.in_data  = {4{16'h000A}};
    for (int t = 0; t < 7; t++) begin
      tick();
      ev = '0;
      ed = '0;
      for (int i = 0; i < NL; i++) begin
        k = t - i;
        if (k == 0) begin
          ev[i]          = 1'b1;
          ed[i*DW +: DW] = 16'h000A;
        end else if (k == 2) begin
          ev[i]          = 1'b1;
          ed[i*DW +: DW] = 16'h000B;
        end
      end
      check($sformatf("gap_v%0d", t), 64'(bus.out_valid), 64'(ev));
      check($sformatf("gap_d%0d", t), 64'(bus.out_data), 64'(ed));
      check($sformatf("gap_ready%0d", t), 64'(bus.in_ready), (t >= 2 && t <= 4) ? 64'd0 : 64'd1);
      check($sformatf("gap_done%0d", t), 64'(bus.drain_done), (t == 5) ? 64'd1 : 64'd0);
      if (t == 1) check("gap_busy", 64'(bus.busy), 64'd1);
      if (t == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;  // ignored without in_valid
      end else if (t == 1) begin
        bus.in_valid = 1'b1;
        bus.in_data  = {4{16'h000B}};
      end else begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
      end
    end

    // 6: 1-lane skewer into the PE model
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'd5;
    bus1.in_last  = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    check("pe_v0", 64'(bus1.out_valid), 64'd1);
    check("pe_d0", 64'(bus1.out_data), 64'd5);
    check("pe_done0", 64'(bus1.drain_done), 64'd1);
    check("pe_ready0", 64'(bus1.in_ready), 64'd1);
    tick();
    check("pe_out", 64'(pe_out), 64'd150);
    check("pe_v1", 64'(bus1.out_valid), 64'd0);
    check("pe_done1", 64'(bus1.drain_done), 64'd0);
    check("pe_busy1", 64'(bus1.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
